// File: rtl/ser_pkg.sv
// ser_pkg: shared FSM state type and word-counter width for the serializer
package ser_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} st_e;
    localparam int TX_COUNT_W = 16;
endpackage

// File: rtl/serializer_nto1_lanes_if.sv
// serializer_nto1_lanes_if: parallel word handshake in, serial lanes and status out
interface serializer_nto1_lanes_if
    import ser_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int LANES  = 1
);
    logic [DATA_W-1:0]     data_in;
    logic                  valid_in;
    logic                  ready_out;
    logic [LANES-1:0]      serial_out;
    logic                  serial_valid;
    logic                  frame_start;
    logic [TX_COUNT_W-1:0] tx_count;
    modport master (
        output data_in, valid_in,
        input  ready_out, serial_out, serial_valid, frame_start, tx_count
    );
    modport slave (
        input  data_in, valid_in,
        output ready_out, serial_out, serial_valid, frame_start, tx_count
    );
endinterface

// File: rtl/ser_hold_buf.sv
// ser_hold_buf: one-entry word buffer that parks the next word while one is shifting
module ser_hold_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full
);
    // load wins the slot; pop frees it once the shifter has taken the word
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            dout <= '0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
        end else if (pop) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/serializer_nto1_lanes.sv
// serializer_nto1_lanes: N-to-1 word serializer over LANES lanes; SER_PARITY_EN appends an even-parity beat
module serializer_nto1_lanes
    import ser_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 1
) (
    input logic                    clk_serial,
    input logic                    rst,
    serializer_nto1_lanes_if.slave bus
);
    localparam int BEATS = DATA_W / LANES;
    localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;

    st_e                   state;
    logic [DATA_W-1:0]     sh;
    logic [DATA_W-1:0]     hold_q;
    logic [DATA_W-1:0]     lw;
    logic [CW-1:0]         cnt;
    logic [LANES-1:0]      so;
    logic                  sv;
    logic                  fs;
    logic [TX_COUNT_W-1:0] txc;
    logic                  full;
    logic                  accept;
    logic                  last_data;
    logic                  fin;
    logic                  do_load;
`ifdef SER_PARITY_EN
    logic                  par;
`endif

    function automatic logic [LANES-1:0] head(input logic [DATA_W-1:0] w);
        return MSB_FIRST != 0 ? w[DATA_W-1 -: LANES] : w[LANES-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return MSB_FIRST != 0 ? w << LANES : w >> LANES;
    endfunction

    assign accept    = bus.valid_in && !full;
    assign last_data = state == SHIFT && cnt == CW'(BEATS - 1);
`ifdef SER_PARITY_EN
    assign fin       = state == PARITY;
`else
    assign fin       = last_data;
`endif
    // a waiting held word always has priority over the input port at a word boundary
    assign do_load   = (state == IDLE && accept) || (fin && (full || accept));
    assign lw        = full ? hold_q : bus.data_in;

    ser_hold_buf #(.W(DATA_W)) u_hold (
        .clk  (clk_serial),
        .rst  (rst),
        .load (accept && state != IDLE && !fin),
        .pop  (fin && full),
        .din  (bus.data_in),
        .dout (hold_q),
        .full (full)
    );

    // word sequencer: load, shift one slice per cycle, optional parity beat, then reload or idle
    always_ff @(posedge clk_serial) begin
        if (rst) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
            so    <= '0;
            sv    <= 1'b0;
            fs    <= 1'b0;
            txc   <= '0;
`ifdef SER_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            if (fin) txc <= txc + 1'b1;
            if (do_load) begin
                state <= SHIFT;
                sh    <= advance(lw);
                so    <= head(lw);
                sv    <= 1'b1;
                fs    <= 1'b1;
                cnt   <= '0;
`ifdef SER_PARITY_EN
                par   <= ^lw;
`endif
            end else if (state == SHIFT && !last_data) begin
                sh    <= advance(sh);
                so    <= head(sh);
                fs    <= 1'b0;
                cnt   <= cnt + 1'b1;
`ifdef SER_PARITY_EN
            end else if (last_data) begin
                state <= PARITY;
                so    <= LANES'(par);
                fs    <= 1'b0;
`endif
            end else begin
                state <= IDLE;
                so    <= '0;
                sv    <= 1'b0;
                fs    <= 1'b0;
            end
        end
    end

    assign bus.ready_out    = !full;
    assign bus.serial_out   = so;
    assign bus.serial_valid = sv;
    assign bus.frame_start  = fs;
    assign bus.tx_count     = txc;
endmodule

// File: tb/tb_serializer_nto1_lanes.sv
// tb_serializer_nto1_lanes: directed checks of ordering, back-pressure, reset and counter wrap
module tb_serializer_nto1_lanes;
    import ser_pkg::*;
`ifdef SER_PARITY_EN
    localparam int PX = 1;
`else
    localparam int PX = 0;
`endif
    localparam int L2 = PX != 0 ? 1 : 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serializer_nto1_lanes_if #(.DATA_W(64), .LANES(1))  b0 ();
    serializer_nto1_lanes_if #(.DATA_W(64), .LANES(4))  b1 ();
    serializer_nto1_lanes_if #(.DATA_W(8),  .LANES(L2)) b2 ();

    serializer_nto1_lanes #(.DATA_W(64), .LANES(1), .MSB_FIRST(1)) u0 (.clk_serial(clk), .rst(rst), .bus(b0));
    serializer_nto1_lanes #(.DATA_W(64), .LANES(4), .MSB_FIRST(0)) u1 (.clk_serial(clk), .rst(rst), .bus(b1));
    serializer_nto1_lanes #(.DATA_W(8),  .LANES(L2), .MSB_FIRST(1)) u2 (.clk_serial(clk), .rst(rst), .bus(b2));

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        b0.valid_in = 1'b0; b0.data_in = '0;
        b1.valid_in = 1'b0; b1.data_in = '0;
        b2.valid_in = 1'b0; b2.data_in = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (b0.ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", b0.ready_out); end
        checks++; if (b0.serial_valid !== 1'b0) begin errors++; $display("FAIL reset_sv got %b want 0", b0.serial_valid); end
        checks++; if (b0.serial_out !== 1'b0) begin errors++; $display("FAIL reset_so got %b want 0", b0.serial_out); end
        checks++; if (b0.frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", b0.frame_start); end
        checks++; if (b0.tx_count !== 16'h0) begin errors++; $display("FAIL reset_tx got %h want 0000", b0.tx_count); end
        checks++; if (b1.ready_out !== 1'b1 || b1.serial_valid !== 1'b0) begin errors++; $display("FAIL reset_u1 got rdy=%b sv=%b want 1/0", b1.ready_out, b1.serial_valid); end
        checks++; if (b2.serial_out !== '0 || b2.tx_count !== 16'h0) begin errors++; $display("FAIL reset_u2 got so=%h tx=%h want 0/0", b2.serial_out, b2.tx_count); end
    endtask

    task automatic test_single();
        logic [63:0] w = 64'hAAAABBBB12345678;
        logic [63:0] got = '0;
        logic        second = 1'bx;
        logic [15:0] tx_mid = 16'hx;
        int nv = 0, nfs = 0, lastc = 0;
        apply_reset();
        b0.data_in = w; b0.valid_in = 1'b1;
        @(negedge clk);
        b0.valid_in = 1'b0;
        checks++; if (b0.serial_valid !== 1'b1 || b0.frame_start !== 1'b1) begin errors++; $display("FAIL single_lat1 got sv=%b fs=%b want 1/1", b0.serial_valid, b0.frame_start); end
        checks++; if (b0.serial_out !== 1'b1) begin errors++; $display("FAIL single_first_bit got %b want 1", b0.serial_out); end
        for (int c = 1; c <= 64 + PX + 4; c++) begin
            if (c == 64 + PX) tx_mid = b0.tx_count;
            if (b0.serial_valid) begin
                if (nv < 64) got = {got[62:0], b0.serial_out[0]};
                if (nv == 1) second = b0.serial_out[0];
                nv++;
                lastc = c;
            end
            if (b0.frame_start) nfs++;
            @(negedge clk);
        end
        checks++; if (second !== 1'b0) begin errors++; $display("FAIL single_second_bit got %b want 0", second); end
        checks++; if (nv != 64 + PX || lastc != 64 + PX) begin errors++; $display("FAIL single_valid_span got n=%0d last=%0d want %0d/%0d", nv, lastc, 64 + PX, 64 + PX); end
        checks++; if (got !== w) begin errors++; $display("FAIL single_word got %h want %h", got, w); end
        checks++; if (nfs != 1) begin errors++; $display("FAIL single_fs_count got %0d want 1", nfs); end
        checks++; if (tx_mid !== 16'h0) begin errors++; $display("FAIL single_tx_mid got %h want 0000", tx_mid); end
        checks++; if (b0.tx_count !== 16'h1) begin errors++; $display("FAIL single_tx got %h want 0001", b0.tx_count); end
        checks++; if (b0.serial_valid !== 1'b0 || b0.serial_out !== 1'b0) begin errors++; $display("FAIL single_idle got sv=%b so=%b want 0/0", b0.serial_valid, b0.serial_out); end
    endtask

    task automatic test_lanes4();
        logic [63:0] w1 = 64'h0123456789ABCDEF;
        logic [63:0] w2 = 64'hFEDCBA9876543210;
        logic [63:0] g1 = '0, g2 = '0;
        logic [3:0]  first = 4'hx;
        logic        rdy2 = 1'bx;
        int nv = 0, fs_good = 0, fs_bad = 0, lastc = 0;
        apply_reset();
        b1.data_in = w1; b1.valid_in = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 2 * (16 + PX) + 4; c++) begin
            if (c == 1) b1.data_in = w2;
            if (c == 2) begin rdy2 = b1.ready_out; b1.valid_in = 1'b0; end
            if (b1.serial_valid) begin
                if (nv == 0) first = b1.serial_out;
                if (nv < 16) g1 = g1 | (64'(b1.serial_out) << (4 * nv));
                else if (nv >= 16 + PX && nv < 32 + PX) g2 = g2 | (64'(b1.serial_out) << (4 * (nv - 16 - PX)));
                if (b1.frame_start) begin
                    if (nv == 0 || nv == 16 + PX) fs_good++; else fs_bad++;
                end
                nv++;
                lastc = c;
            end else if (b1.frame_start) fs_bad++;
            @(negedge clk);
        end
        checks++; if (first !== 4'hF) begin errors++; $display("FAIL lanes4_first got %h want f", first); end
        checks++; if (g1 !== w1) begin errors++; $display("FAIL lanes4_word1 got %h want %h", g1, w1); end
        checks++; if (g2 !== w2) begin errors++; $display("FAIL lanes4_word2 got %h want %h", g2, w2); end
        checks++; if (nv != 32 + 2 * PX || lastc != 32 + 2 * PX) begin errors++; $display("FAIL lanes4_no_gap got n=%0d last=%0d want %0d", nv, lastc, 32 + 2 * PX); end
        checks++; if (fs_good != 2 || fs_bad != 0) begin errors++; $display("FAIL lanes4_fs got good=%0d bad=%0d want 2/0", fs_good, fs_bad); end
        checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL lanes4_ready_drop got %b want 0", rdy2); end
        checks++; if (b1.tx_count !== 16'h2) begin errors++; $display("FAIL lanes4_tx got %h want 0002", b1.tx_count); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] wv [3] = '{64'hDEADBEEF00FF1234, 64'h0F0F0F0FA5A5C3C3, 64'h8000000000000001};
        int acc [3] = '{-1, -1, -1};
        int idx = 0, nacc = 0, nv = 0, nfs = 0, lastc = 0, bad = 0, wd, bi;
        logic pend = 1'b0;
        logic rdy2 = 1'bx;
        apply_reset();
        b0.data_in = wv[0]; b0.valid_in = 1'b1;
        for (int c = 0; c < 3 * (64 + PX) + 8; c++) begin
            if (pend) begin
                idx++;
                if (idx < 3) b0.data_in = wv[idx]; else b0.valid_in = 1'b0;
                pend = 1'b0;
            end
            if (c == 2) rdy2 = b0.ready_out;
            if (b0.serial_valid) begin
                wd = nv / (64 + PX);
                bi = nv % (64 + PX);
                if (wd < 3 && bi < 64 && b0.serial_out[0] !== wv[wd][63 - bi]) bad++;
                nv++;
                lastc = c;
            end
            if (b0.frame_start) nfs++;
            if (b0.valid_in && b0.ready_out) begin
                pend = 1'b1;
                if (nacc < 3) acc[nacc] = c;
                nacc++;
            end
            @(negedge clk);
        end
        checks++; if (nacc != 3) begin errors++; $display("FAIL b2b_accepts got %0d want 3", nacc); end
        checks++; if (acc[0] != 0 || acc[1] != 1) begin errors++; $display("FAIL b2b_first_accepts got %0d,%0d want 0,1", acc[0], acc[1]); end
        checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop got %b want 0", rdy2); end
        checks++; if (acc[2] != 65 + PX) begin errors++; $display("FAIL b2b_third_accept got %0d want %0d", acc[2], 65 + PX); end
        checks++; if (nv != 3 * (64 + PX) || lastc != 3 * (64 + PX)) begin errors++; $display("FAIL b2b_contiguous got n=%0d last=%0d want %0d", nv, lastc, 3 * (64 + PX)); end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_bits got %0d wrong want 0", bad); end
        checks++; if (nfs != 3) begin errors++; $display("FAIL b2b_fs got %0d want 3", nfs); end
        checks++; if (b0.tx_count !== 16'h3) begin errors++; $display("FAIL b2b_tx got %h want 0003", b0.tx_count); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] wc = 64'hC3A5_0000_FFFF_1E2D;
        logic [63:0] got = '0;
        logic rdy2;
        int nv = 0;
        apply_reset();
        b0.data_in = 64'h1234_5678_9ABC_DEF0; b0.valid_in = 1'b1;
        @(negedge clk);
        b0.data_in = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        b0.valid_in = 1'b0;
        rdy2 = b0.ready_out;
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL rstmid_hold_full got rdy=%b want 0", rdy2); end
        checks++; if (b0.serial_valid !== 1'b0 || b0.frame_start !== 1'b0) begin errors++; $display("FAIL rstmid_sv got sv=%b fs=%b want 0/0", b0.serial_valid, b0.frame_start); end
        checks++; if (b0.ready_out !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", b0.ready_out); end
        checks++; if (b0.tx_count !== 16'h0) begin errors++; $display("FAIL rstmid_tx got %h want 0000", b0.tx_count); end
        b0.data_in = wc; b0.valid_in = 1'b1;
        @(negedge clk);
        b0.valid_in = 1'b0;
        for (int c = 1; c <= 64 + PX + 3; c++) begin
            if (b0.serial_valid) begin
                if (nv < 64) got = {got[62:0], b0.serial_out[0]};
                nv++;
            end
            @(negedge clk);
        end
        checks++; if (got !== wc || nv != 64 + PX) begin errors++; $display("FAIL rstmid_next_word got %h n=%0d want %h n=%0d", got, nv, wc, 64 + PX); end
        checks++; if (b0.tx_count !== 16'h1) begin errors++; $display("FAIL rstmid_next_tx got %h want 0001", b0.tx_count); end
    endtask

`ifdef SER_PARITY_EN
    task automatic test_parity();
        logic [8:0]  seq = '0;
        logic [15:0] tx9 = 16'hx;
        int nv = 0, nfs = 0;
        apply_reset();
        b2.data_in = 8'h07; b2.valid_in = 1'b1;
        @(negedge clk);
        b2.valid_in = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 9) tx9 = b2.tx_count;
            if (b2.serial_valid) begin
                seq = {seq[7:0], b2.serial_out[0]};
                nv++;
            end
            if (b2.frame_start) nfs++;
            @(negedge clk);
        end
        checks++; if (nv != 9) begin errors++; $display("FAIL parity_beats got %0d want 9", nv); end
        checks++; if (seq !== 9'b000001111) begin errors++; $display("FAIL parity_seq got %b want 000001111", seq); end
        checks++; if (nfs != 1) begin errors++; $display("FAIL parity_fs got %0d want 1", nfs); end
        checks++; if (tx9 !== 16'h0) begin errors++; $display("FAIL parity_tx_before got %h want 0000", tx9); end
        checks++; if (b2.tx_count !== 16'h1) begin errors++; $display("FAIL parity_tx_after got %h want 0001", b2.tx_count); end
    endtask
`else
    task automatic test_wrap();
        logic sv_run, fs_run;
        apply_reset();
        b2.valid_in = 1'b1;
        repeat (65535) begin
            b2.data_in = b2.data_in + 8'h01;
            @(negedge clk);
        end
        sv_run = b2.serial_valid;
        fs_run = b2.frame_start;
        b2.valid_in = 1'b0;
        @(negedge clk);
        checks++; if (sv_run !== 1'b1 || fs_run !== 1'b1) begin errors++; $display("FAIL wrap_stream got sv=%b fs=%b want 1/1", sv_run, fs_run); end
        checks++; if (b2.tx_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got %h want ffff", b2.tx_count); end
        b2.data_in = 8'h5A; b2.valid_in = 1'b1;
        @(negedge clk);
        b2.valid_in = 1'b0;
        checks++; if (b2.serial_out !== 8'h5A) begin errors++; $display("FAIL wrap_word got %h want 5a", b2.serial_out); end
        @(negedge clk);
        checks++; if (b2.tx_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h want 0000", b2.tx_count); end
    endtask
`endif

    initial begin
        b0.valid_in = 1'b0; b0.data_in = '0;
        b1.valid_in = 1'b0; b1.data_in = '0;
        b2.valid_in = 1'b0; b2.data_in = '0;
        test_reset();
        test_single();
        test_lanes4();
        test_back_to_back();
        test_reset_mid();
`ifdef SER_PARITY_EN
        test_parity();
`else
        test_wrap();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serializer_nto1_lanes.md
SERIALIZER_NTO1_LANES -- requirements
Module: serializer_nto1_lanes

Interface
REQ-001 SHALL have parameter DATA_W, default 64: parallel word width; legal values 8..256.
REQ-002 SHALL have parameter LANES, default 1: serial output lanes; SHALL divide DATA_W exactly; legal values 1, 2, 4, 8.
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 = most-significant slice first; 0 = least-significant slice first.
REQ-004 SHALL have port clk_serial, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port data_in, input, DATA_W bits: word to serialise.
REQ-007 SHALL have port valid_in, input, 1 bit: data_in is valid.
REQ-008 SHALL have port ready_out, output, 1 bit: block accepts a word this cycle.
REQ-009 SHALL have port serial_out, output, LANES bits: current serial slice.
REQ-010 SHALL have port serial_valid, output, 1 bit: serial_out carries a data or parity beat.
REQ-011 SHALL have port frame_start, output, 1 bit: high on the first beat of each word.
REQ-012 SHALL have port tx_count, output, 16 bits: count of completed words, wrapping.

Function
REQ-013 SHALL define BEATS = DATA_W/LANES; each word SHALL occupy exactly BEATS data beats.
REQ-014 A word SHALL be accepted only on an edge where valid_in && ready_out; valid_in without ready_out SHALL have no effect.
REQ-015 Storage SHALL be one shift register plus a one-entry holding buffer; ready_out SHALL equal !hold_full, registered, with no combinational path from valid_in.
REQ-016 FSM states: IDLE (nothing shifting) and SHIFT (data beats); PARITY is added when REQ-027 is compiled in.
REQ-017 IDLE with accept at edge N: word SHALL load directly into the shift register; serial_valid and frame_start SHALL be high in cycle N+1 (latency 1).
REQ-018 SHIFT with accept: word SHALL go to the holding buffer, and ready_out SHALL drop the next cycle.
REQ-019 At the last beat with hold_full: hold SHALL move to the shift register with no gap cycle; hold_full SHALL clear; frame_start SHALL be high on the next beat.
REQ-020 At the last beat with hold empty and a simultaneous accept: the new word SHALL load straight into the shift register with no gap.
REQ-021 At the last beat with no pending word: the FSM SHALL go to IDLE.
REQ-022 MSB_FIRST=1: beat k SHALL present data[DATA_W-1-k*LANES -: LANES]. MSB_FIRST=0: beat k SHALL present data[k*LANES +: LANES]. Within a slice, bit i SHALL map to lane i.
REQ-023 In IDLE, serial_out and serial_valid SHALL be 0.
REQ-024 tx_count SHALL increment by 1 when the final beat of a word (data or parity) is emitted, and SHALL wrap 0xFFFF -> 0x0000.
REQ-025 The beat counter SHALL be $clog2(BEATS) bits wide, with a minimum of 1 bit.

Reset
REQ-026 When rst=1 at a clock edge: FSM -> IDLE; shift, hold and beat counter cleared; hold_full=0; ready_out=1; serial_out=0; serial_valid=0; frame_start=0; tx_count=0. Reset mid-word SHALL discard the word and the held word, and the partial word SHALL NOT be counted.

Configuration
REQ-027 Macro SER_PARITY_EN: when defined, one PARITY beat SHALL follow the last data beat of each word. In it, serial_out[0] = even parity (XOR-reduce) of the word, other lanes = 0, serial_valid=1, frame_start=0. REQ-019/020 then apply at the parity beat, and each word takes BEATS+1 cycles.
REQ-028 Without SER_PARITY_EN: no PARITY state, and no parity logic SHALL be synthesised.

Structure
REQ-029 A shared package ser_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, PARITY) and the TX_COUNT_W=16 constant.
REQ-030 One sub-module, ser_hold_buf (one-entry valid/data register with load/pop), is natural; everything else SHALL be in the top module.

Verification
REQ-031 Defaults, one word 0xAAAABBBB12345678 accepted at edge N: serial_valid high cycles N+1..N+64; first bit 1, second 0; frame_start only in cycle N+1; tx_count=1.
REQ-032 LANES=4, MSB_FIRST=0, word 0x0123456789ABCDEF: 16 beats in order F, E, D, ... 0; back-to-back second word: no gap cycle, frame_start on beat 17.
REQ-033 Hold valid_in=1 with 3 words: ready_out SHALL fall after the second accept; the third word is accepted only after the first finishes; total 192 contiguous valid beats.
REQ-034 Assert rst=1 at beat 20 of a word with hold_full: next cycle serial_valid=0, ready_out=1, tx_count=0; a following word serialises correctly.
REQ-035 SER_PARITY_EN, DATA_W=8, word 0x07: beats 0,0,0,0,0,1,1,1 then parity beat serial_out[0]=1; 9 valid cycles; tx_count increments after the parity beat.
REQ-036 Preload tx_count=0xFFFF via 65535 words (or force): next completion SHALL produce 0x0000.
